// File: rtl/mtr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mtr_pkg
//  Description : Shared types and helpers for the multi-channel H-bridge
//                PWM driver (bridge state enum, signed target, slew step).
//  Revision    : 1.0 - initial release
// ============================================================================
package mtr_pkg;

    // Bridge state of one motor channel
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FWD  = 3'd1,
        ST_REV  = 3'd2,
        ST_BRK  = 3'd3,
        ST_DEAD = 3'd4
    } state_t;

    // Signed target from magnitude and direction (1 = reverse)
    function automatic int mk_tgt(input int mag, input logic neg);
        return neg ? -mag : mag;
    endfunction

    // Step that moves app toward tgt by at most 'step' and never past it.
    // Evaluated at 32 bits, wider than the SPD_W+2 needed for the difference.
    function automatic int slew_step(input int tgt, input int app, input int step);
        int diff;
        diff = tgt - app;
        if (diff > step)
            return step;
        else if (diff < -step)
            return -step;
        else
            return diff;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mtr_drv_multi_ch.sv
`default_nettype none
// ============================================================================
//  Module      : mtr_ch
//  Description : One H-bridge channel: bridge-state FSM, signed slew register,
//                dead-time counter and registered PWM leg outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module mtr_ch
    import mtr_pkg::*;
#(
    parameter int SPD_W     = 11,
    parameter int DEAD_CYC  = 32,
    parameter int SLEW_STEP = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             strobe,
    input  logic [SPD_W-1:0] cnt,
    input  logic [SPD_W-1:0] spd,
    input  logic             rev,
    input  logic             brake,
    output logic             pwm_frwrd,
    output logic             pwm_rev,
    output logic             at_target
);

    localparam int         AW        = SPD_W + 1;
    localparam logic [7:0] DEAD_LAST = 8'(DEAD_CYC - 1);

    state_t                 state, state_nxt;
    logic                   pend_brk, pend_nxt;
    logic [7:0]             dcnt, dcnt_nxt;
    logic signed [AW-1:0]   app, app_nxt, slewed, tgt, tgt_in;
    logic [SPD_W-1:0]       mag_nxt;
    logic                   slew_neg, slew_pos;
    logic                   fwd_nxt, rev_nxt;

    // Next-state, slew and next-output logic
    always_comb begin
        tgt_in    = AW'(mk_tgt(int'(spd), rev));
        slewed    = strobe ? AW'(int'(app) + slew_step(int'(tgt_in), int'(app), SLEW_STEP))
                           : app;
        slew_neg  = slewed[AW-1];
        slew_pos  = !slewed[AW-1] && (slewed != '0);
        state_nxt = state;
        pend_nxt  = pend_brk;
        dcnt_nxt  = dcnt;
        app_nxt   = slewed;
        if (!en) begin
            state_nxt = ST_IDLE;
            pend_nxt  = 1'b0;
            dcnt_nxt  = '0;
            app_nxt   = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    app_nxt   = '0;
                    state_nxt = ST_DEAD;
                    pend_nxt  = brake;
                    dcnt_nxt  = '0;
                end
                ST_FWD, ST_REV: begin
                    if (brake) begin
                        app_nxt   = '0;
                        state_nxt = ST_DEAD;
                        pend_nxt  = 1'b1;
                        dcnt_nxt  = '0;
                    end else if ((state == ST_FWD && slew_neg) ||
                                 (state == ST_REV && slew_pos)) begin
                        state_nxt = ST_DEAD;
                        pend_nxt  = 1'b0;
                        dcnt_nxt  = '0;
                    end
                end
                ST_BRK: begin
                    app_nxt = '0;
                    if (!brake) begin
                        state_nxt = ST_DEAD;
                        pend_nxt  = 1'b0;
                        dcnt_nxt  = '0;
                    end
                end
                ST_DEAD: begin
                    // A late brake retargets the pending state; count continues
                    pend_nxt = pend_brk | brake;
                    if (pend_nxt)
                        app_nxt = '0;
                    if (dcnt == DEAD_LAST)
                        state_nxt = pend_nxt ? ST_BRK : (app_nxt[AW-1] ? ST_REV : ST_FWD);
                    else
                        dcnt_nxt = dcnt + 8'd1;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
        mag_nxt = app_nxt[AW-1] ? SPD_W'(-app_nxt) : SPD_W'(app_nxt);
        fwd_nxt = (state_nxt == ST_BRK) || (state_nxt == ST_FWD && cnt < mag_nxt);
        rev_nxt = (state_nxt == ST_BRK) || (state_nxt == ST_REV && cnt < mag_nxt);
    end

    // State, slew, dead counter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            pend_brk  <= 1'b0;
            dcnt      <= '0;
            app       <= '0;
            tgt       <= '0;
            pwm_frwrd <= 1'b0;
            pwm_rev   <= 1'b0;
        end else begin
            state     <= state_nxt;
            pend_brk  <= pend_nxt;
            dcnt      <= dcnt_nxt;
            app       <= app_nxt;
            if (strobe)
                tgt <= tgt_in;
            pwm_frwrd <= fwd_nxt;
            pwm_rev   <= rev_nxt;
        end
    end

    assign at_target = (app == tgt) && (state == ST_FWD || state == ST_REV);

endmodule
`default_nettype wire

// File: rtl/mtr_drv_multi.sv
`default_nettype none
// ============================================================================
//  Module      : mtr_drv_multi
//  Description : NUM_CH-channel H-bridge PWM driver sharing one PWM counter;
//                per-channel slew limiting, dead time, brake, global enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module mtr_drv_multi
    import mtr_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int SPD_W     = 11,
    parameter int DEAD_CYC  = 32,
    parameter int SLEW_STEP = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [NUM_CH*SPD_W-1:0] spd,
    input  logic [NUM_CH-1:0]       rev,
    input  logic [NUM_CH-1:0]       brake,
    output logic [NUM_CH-1:0]       PWM_frwrd,
    output logic [NUM_CH-1:0]       PWM_rev,
    output logic [NUM_CH-1:0]       at_target
);

    logic [SPD_W-1:0] cnt;
    logic             strobe;

    // Free-running PWM period counter shared by every channel
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign strobe = (cnt == '0);

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            mtr_ch #(
                .SPD_W     (SPD_W),
                .DEAD_CYC  (DEAD_CYC),
                .SLEW_STEP (SLEW_STEP)
            ) u_ch (
                .clk       (clk),
                .rst       (rst),
                .en        (en),
                .strobe    (strobe),
                .cnt       (cnt),
                .spd       (spd[i*SPD_W +: SPD_W]),
                .rev       (rev[i]),
                .brake     (brake[i]),
                .pwm_frwrd (PWM_frwrd[i]),
                .pwm_rev   (PWM_rev[i]),
                .at_target (at_target[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire
